// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PSR bit positions, branch condition codes and
// default datapath widths used by the ALU back end and the branch unit.
package cpu_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int AW_DEFAULT    = 4;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } bufState_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch/jump condition evaluator; shared with the branch unit.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [4:0] psr,
    input  logic [3:0] cond,
    output logic       condTrue
);

    always_comb begin
        condTrue = 1'b0;
        case (cond)
            COND_EQ: condTrue = psr[PSR_Z];
            COND_NE: condTrue = ~psr[PSR_Z];
            COND_CS: condTrue = psr[PSR_C];
            COND_CC: condTrue = ~psr[PSR_C];
            COND_HI: condTrue = psr[PSR_L];
            COND_LS: condTrue = ~psr[PSR_L];
            COND_GT: condTrue = psr[PSR_N];
            COND_LE: condTrue = ~psr[PSR_N];
            COND_FS: condTrue = psr[PSR_F];
            COND_FC: condTrue = ~psr[PSR_F];
            COND_LO: condTrue = ~psr[PSR_L] & ~psr[PSR_Z];
            COND_HS: condTrue = psr[PSR_L] | psr[PSR_Z];
            COND_LT: condTrue = ~psr[PSR_N] & ~psr[PSR_Z];
            COND_GE: condTrue = psr[PSR_N] | psr[PSR_Z];
            COND_UC: condTrue = 1'b1;
            COND_NV: condTrue = 1'b0;
            default: condTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: PSR owner, two-entry in-order register-file write
// buffer, operand forwarding lookup and condition-code evaluation.
module alu_writeback_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [AW-1:0]    in_dst,
    input  logic             in_wr_en,
    input  logic [4:0]       in_flag_mask,
    input  logic             carry,
    input  logic             low,
    input  logic             flag,
    input  logic             zero,
    input  logic             negative,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    input  logic             rf_ready,
    output logic [4:0]       psr,
    input  logic [AW-1:0]    fwd_raddr,
    output logic             fwd_hit,
    output logic [WIDTH-1:0] fwd_data,
    input  logic [3:0]       cond,
    output logic             cond_true
);

    bufState_t        stateReg;
    logic [WIDTH-1:0] dataReg [2];
    logic [AW-1:0]    dstReg  [2];
    logic [4:0]       psrReg;
    logic [4:0]       psrNext;
    logic [4:0]       newFlags;
    logic             accept;
    logic             enqueue;
    logic             drain;
    logic             hitHead;
    logic             hitTail;

    assign newFlags = {negative, zero, flag, low, carry};
    assign in_ready = ~reset & (stateReg != BUF_TWO);
    assign accept   = in_valid & in_ready;
    assign enqueue  = accept & in_wr_en;
    assign rf_we    = (stateReg != BUF_EMPTY);
    assign drain    = rf_we & rf_ready;

    // Slot 0 is always the head (oldest); slot 1 only holds data in BUF_TWO.
    assign rf_waddr = dstReg[0];
    assign rf_wdata = dataReg[0];
    assign psr      = psrReg;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_psrBit
            assign psrNext[gi] = (accept & in_flag_mask[gi]) ? newFlags[gi] : psrReg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= BUF_EMPTY;
            psrReg     <= '0;
            dataReg[0] <= '0;
            dataReg[1] <= '0;
            dstReg[0]  <= '0;
            dstReg[1]  <= '0;
        end else begin
            psrReg <= psrNext;
            case (stateReg)
                BUF_EMPTY: begin
                    if (enqueue) begin
                        dataReg[0] <= in_result;
                        dstReg[0]  <= in_dst;
                        stateReg   <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (enqueue && drain) begin
                        dataReg[0] <= in_result;
                        dstReg[0]  <= in_dst;
                    end else if (enqueue) begin
                        dataReg[1] <= in_result;
                        dstReg[1]  <= in_dst;
                        stateReg   <= BUF_TWO;
                    end else if (drain) begin
                        stateReg <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        dataReg[0] <= dataReg[1];
                        dstReg[0]  <= dstReg[1];
                        stateReg   <= BUF_ONE;
                    end
                end
                default: stateReg <= BUF_EMPTY;
            endcase
        end
    end

    // Tail wins when both slots target the same register: it is the younger write.
    assign hitHead = (stateReg != BUF_EMPTY) && (dstReg[0] == fwd_raddr);
    assign hitTail = (stateReg == BUF_TWO) && (dstReg[1] == fwd_raddr);

    always_comb begin
        fwd_hit  = hitHead | hitTail;
        fwd_data = '0;
        if (hitTail)
            fwd_data = dataReg[1];
        else if (hitHead)
            fwd_data = dataReg[0];
    end

    cond_eval u_condEval (
        .psr      (psrReg),
        .cond     (cond),
        .condTrue (cond_true)
    );

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: condition-code vector table,
// scoreboard of expected register-file writes, and multi-cycle corner cases.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_dst;
    logic        in_wr_en;
    logic [4:0]  in_flag_mask;
    logic        carry, low, flag, zero, negative;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic [4:0]  psr;
    logic [3:0]  fwd_raddr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [3:0]  cond;
    logic        cond_true;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] data;
    } wr_t;
    wr_t sbQ[$];

    typedef struct {
        logic [4:0] flags;
        logic [3:0] cond;
        logic       expTrue;
    } vec_t;
    vec_t vecs[19];

    alu_writeback_stage #(.WIDTH(16), .AW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_dst       (in_dst),
        .in_wr_en     (in_wr_en),
        .in_flag_mask (in_flag_mask),
        .carry        (carry),
        .low          (low),
        .flag         (flag),
        .zero         (zero),
        .negative     (negative),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_ready     (rf_ready),
        .psr          (psr),
        .fwd_raddr    (fwd_raddr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .cond         (cond),
        .cond_true    (cond_true)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Every completed register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && rf_we && rf_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stale_write: got addr=%0d data=0x%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = sbQ.pop_front();
                chk("wb_addr", 32'(rf_waddr), 32'(e.dst));
                chk("wb_data", 32'(rf_wdata), 32'(e.data));
            end
        end
    end

    task automatic doAccept(input logic [15:0] res, input logic [3:0] dst, input logic we,
                            input logic [4:0] mask, input logic [4:0] flags);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
            return;
        end
        in_valid     = 1'b1;
        in_result    = res;
        in_dst       = dst;
        in_wr_en     = we;
        in_flag_mask = mask;
        {negative, zero, flag, low, carry} = flags;
        if (we) sbQ.push_back('{dst, res});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{5'b01000, 4'd0,  1'b1};
        vecs[1]  = '{5'b01000, 4'd1,  1'b0};
        vecs[2]  = '{5'b00001, 4'd2,  1'b1};
        vecs[3]  = '{5'b00001, 4'd3,  1'b0};
        vecs[4]  = '{5'b00010, 4'd4,  1'b1};
        vecs[5]  = '{5'b00000, 4'd5,  1'b1};
        vecs[6]  = '{5'b10000, 4'd6,  1'b1};
        vecs[7]  = '{5'b10000, 4'd7,  1'b0};
        vecs[8]  = '{5'b00100, 4'd8,  1'b1};
        vecs[9]  = '{5'b00100, 4'd9,  1'b0};
        vecs[10] = '{5'b00000, 4'd10, 1'b1};
        vecs[11] = '{5'b00010, 4'd10, 1'b0};
        vecs[12] = '{5'b01000, 4'd11, 1'b1};
        vecs[13] = '{5'b00000, 4'd12, 1'b1};
        vecs[14] = '{5'b10000, 4'd12, 1'b0};
        vecs[15] = '{5'b01000, 4'd13, 1'b1};
        vecs[16] = '{5'b00000, 4'd13, 1'b0};
        vecs[17] = '{5'b00000, 4'd14, 1'b1};
        vecs[18] = '{5'b11111, 4'd15, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_result = '0; in_dst = '0; in_wr_en = 1'b0;
        in_flag_mask = '0; {negative, zero, flag, low, carry} = 5'b0;
        rf_ready = 1'b0; fwd_raddr = '0; cond = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready_low", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_psr", 32'(psr), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("reset_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("reset_fwd_data", 32'(fwd_data), 32'd0);
        chk("reset_in_ready_high", 32'(in_ready), 32'd1);

        // First write with all flags updated
        rf_ready = 1'b1;
        doAccept(16'h1234, 4'd3, 1'b1, 5'b11111, 5'b00001);
        cond = 4'd2;
        #1;
        chk("first_rf_we", 32'(rf_we), 32'd1);
        chk("first_rf_waddr", 32'(rf_waddr), 32'd3);
        chk("first_rf_wdata", 32'(rf_wdata), 32'h1234);
        chk("first_psr", 32'(psr), 32'b00001);
        chk("first_cond_cs", 32'(cond_true), 32'd1);
        waitDrain("first_drain");

        // Condition-code table via flags-only accepts
        for (int i = 0; i < 19; i++) begin
            doAccept(16'hDEAD, 4'd1, 1'b0, 5'b11111, vecs[i].flags);
            cond = vecs[i].cond;
            #1;
            chk($sformatf("vec%0d_psr", i), 32'(psr), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_cond%0d", i, vecs[i].cond), 32'(cond_true), 32'(vecs[i].expTrue));
            chk($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'd0);
        end

        // Fill buffer with rf_ready low; same-cycle accept is not forwarded
        rf_ready  = 1'b0;
        fwd_raddr = 4'd5;
        @(negedge clk);
        in_valid = 1'b1; in_result = 16'h00AA; in_dst = 4'd5; in_wr_en = 1'b1; in_flag_mask = 5'b0;
        sbQ.push_back('{4'd5, 16'h00AA});
        #1;
        chk("fwd_same_cycle_hidden", 32'(fwd_hit), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("fwd_one_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_one_data", 32'(fwd_data), 32'h00AA);
        doAccept(16'h00BB, 4'd5, 1'b1, 5'b00000, 5'b11111);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("fwd_youngest_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_youngest_data", 32'(fwd_data), 32'h00BB);
        fwd_raddr = 4'd6;
        #1;
        chk("fwd_miss_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_miss_data", 32'(fwd_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_hold_waddr", 32'(rf_waddr), 32'd5);
            chk("stall_hold_wdata", 32'(rf_wdata), 32'h00AA);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        rf_ready = 1'b1;
        waitDrain("full_drain");

        // Flags-only zero update while empty
        doAccept(16'h5555, 4'd9, 1'b0, 5'b01000, 5'b01000);
        cond = 4'd0;
        #1;
        chk("flagsonly_rf_we", 32'(rf_we), 32'd0);
        chk("flagsonly_psr_z", 32'(psr[3]), 32'd1);
        chk("flagsonly_cond_eq", 32'(cond_true), 32'd1);

        // Partial mask clears only carry
        doAccept(16'h0, 4'd0, 1'b0, 5'b11111, 5'b11111);
        doAccept(16'h0, 4'd0, 1'b0, 5'b00001, 5'b00000);
        #1;
        chk("partial_psr", 32'(psr), 32'b11110);
        cond = 4'd10; #1; chk("partial_cond_lo", 32'(cond_true), 32'd0);
        cond = 4'd11; #1; chk("partial_cond_hs", 32'(cond_true), 32'd1);
        cond = 4'd15; #1; chk("partial_cond_nv", 32'(cond_true), 32'd0);

        // Back-to-back accepts with simultaneous drain
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_wr_en = 1'b1; in_flag_mask = 5'b0;
            in_result = 16'h0100 + 16'(i); in_dst = 4'(i);
            sbQ.push_back('{4'(i), 16'h0100 + 16'(i)});
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("stream_rf_wdata", 32'(rf_wdata), 32'h0100 + 32'(i));
        end
        in_valid = 1'b0;
        waitDrain("stream_drain");

        // Reset while the buffer is full discards both writes
        rf_ready = 1'b0;
        doAccept(16'h00C1, 4'd1, 1'b1, 5'b11111, 5'b10101);
        doAccept(16'h00C2, 4'd2, 1'b1, 5'b00000, 5'b00000);
        chk("pre_reset_full", 32'(in_ready), 32'd0);
        reset = 1'b1;
        sbQ.delete();
        @(posedge clk);
        #1;
        chk("midreset_rf_we", 32'(rf_we), 32'd0);
        chk("midreset_psr", 32'(psr), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        reset    = 1'b0;
        rf_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("postreset_in_ready", 32'(in_ready), 32'd1);
        chk("postreset_rf_we", 32'(rf_we), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("postreset_no_stale", 32'(rf_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Register stage directly downstream of the 16-bit ALU. It captures each ALU result and its five condition flags. It owns the processor status register (PSR) and drains results into the register-file write port through a two-entry in-order buffer. It also answers operand-forwarding queries and evaluates branch/jump condition codes against the committed PSR.

## Interface
Parameters:
- WIDTH, 16, data width; matches ALU and register file
- AW, 4, register address width (16 registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept; `~reset & (count < 2)`
- in_result  in  WIDTH  ALU result
- in_dst  in  AW  destination register
- in_wr_en  in  1  result is written to the register file; 0 = flags-only (e.g. CMP)
- in_flag_mask  in  5  per-bit PSR update enable, order {N,Z,F,L,C}
- carry, low, flag, zero, negative  in  1 each  ALU flags
- rf_we  out  1  register-file write request (head entry valid)
- rf_waddr  out  AW  head entry destination
- rf_wdata  out  WIDTH  head entry data
- rf_ready  in  1  register file accepts the write this cycle
- psr  out  5  committed PSR {N,Z,F,L,C}; psr[0]=C
- fwd_raddr  in  AW  operand register being read
- fwd_hit  out  1  a buffered entry targets fwd_raddr
- fwd_data  out  WIDTH  data of the youngest matching entry
- cond  in  4  condition code under test
- cond_true  out  1  cond evaluated against psr

## Operation
- Accept happens when `in_valid & in_ready`.
- PSR update on accept: bit i takes the new flag when in_flag_mask[i]=1, otherwise it holds. This applies even when in_wr_en=0.
- Entries with in_wr_en=1 are enqueued at the tail. Entries with in_wr_en=0 are never enqueued.
- Buffer FSM states: EMPTY(count 0), ONE(1), TWO(2).
  - Drain = `rf_we & rf_ready`; it pops the head.
  - EMPTY: enqueue → ONE.
  - ONE: enqueue without drain → TWO; drain without enqueue → EMPTY; both → ONE (head replaced by new entry).
  - TWO: in_ready=0, so no enqueue; drain → ONE.
- Writes leave strictly in acceptance order.
- Forwarding:
  - fwd_hit=1 if any valid entry has dst==fwd_raddr.
  - When both entries match, fwd_data comes from the tail (youngest).
  - fwd_data is 0 on a miss.
  - An entry accepted this cycle is not visible until the next cycle.
- Condition codes (cond → cond_true):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 10 LO: !L&!Z
  - 11 HS: L|Z
  - 12 LT: !N&!Z
  - 13 GE: N|Z
  - 14 UC: 1
  - 15 never: 0
- Flag data is not range-checked; the stage stores the bits as given.

## Timing
- Reset values: psr=0, count=0, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_hit=0, fwd_data=0, in_ready=0 while reset is high and 1 on the first cycle after.
- Reset mid-operation discards all buffered writes. No rf_we is issued for them.
- Latency:
  - Accept at edge k → rf_we=1 from cycle k+1.
  - The earliest register-file write completes at edge k+1 if rf_ready=1.
- PSR latency: flags accepted at edge k are visible on psr and cond_true from cycle k+1. cond_true is combinational from psr and cond.
- rf_waddr and rf_wdata must be held stable while `rf_we & !rf_ready`.
- Throughput: one accept per cycle while rf_ready stays high (steady state ONE).
- With rf_ready low: two accepts fill the buffer, then in_ready drops until the next drain.

## Structure
- Shared package `cpu_pkg`:
  - PSR bit index constants PSR_C=0, PSR_L=1, PSR_F=2, PSR_Z=3, PSR_N=4.
  - 4-bit condition-code constants COND_EQ … COND_NV.
  - WIDTH/AW defaults.
- One natural sub-module: `cond_eval` (combinational; psr + cond → cond_true), reused by the branch/jump unit.
- The buffer and PSR stay in the top module.

## Test plan
- After reset, with rf_ready=1: accept {result=0x1234, dst=3, wr_en=1, mask=5'b11111, Z=0,C=1} → next cycle rf_we=1, waddr=3, wdata=0x1234, psr=5'b00001; cond=2 (CS) → cond_true=1.
- With rf_ready=0: accept dst=5/0x00AA, then dst=5/0x00BB → in_ready=0; fwd_raddr=5 → fwd_hit=1, fwd_data=0x00BB. Then raise rf_ready → writes of 0x00AA then 0x00BB in order.
- Flags-only accept (wr_en=0, mask=5'b01000, zero=1) in state EMPTY → count stays 0, rf_we=0, psr[3]=1, cond=0 (EQ) true.
- Partial mask: psr=5'b11111, accept mask=5'b00001, carry=0 → psr=5'b11110. cond=10 (LO) → 0; cond=11 (HS) → 1; cond=15 → 0.
- Simultaneous enqueue and drain in ONE for 8 cycles with incrementing data → count stays 1 and each rf_wdata appears exactly once.
- Assert reset while in TWO → next cycle rf_we=0, psr=0, in_ready=0; the following cycle in_ready=1, and no stale write is ever issued.
